fifo_rd_stream: RTL and testbench

//  Read-side drain engine for the async FIFO. It sits entirely in the rclk domain.
//  It pops words from the FIFO read port (rinc/rEmpty/rData) and presents them as a

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 61 ++++++
 tb/tb_fifo_rd_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for the async FIFO read-side drain engine
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int BUF_DEPTH = 2;

    function automatic logic [2:0] occ_level(input occ_e occ);
        return {1'b0, occ};
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry head/second output buffer with occupancy FSM
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output occ_e             occ,
    output logic [DSIZE-1:0] head
);

    occ_e             occ_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] second_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= OCC_EMPTY;
            head_q   <= '0;
            second_q <= '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= push_data;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        second_q <= push_data;
                        occ_q    <= OCC_TWO;
                    end else if (pop && !push) begin
                        occ_q <= OCC_EMPTY;
                    end else if (push && pop) begin
                        head_q <= push_data;
                    end
                end
                OCC_TWO: begin
                    // The issue rule guarantees no push lands while both slots are full.
                    if (pop) begin
                        head_q <= second_q;
                        occ_q  <= OCC_ONE;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the FIFO read port into a valid/ready stream
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rEmpty,
    input  logic [DSIZE-1:0] rData,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CSIZE-1:0] rd_count
);

    occ_e             occ;
    logic             inflight_q;
    logic             inflight_d;
    logic [CSIZE-1:0] count_q;
    logic [CSIZE-1:0] count_d;
    logic             pop;
    logic [2:0]       load_after;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Slots still claimed once this cycle's pop retires; a new read needs one free.
    assign load_after = occ_level(occ) + {2'b00, inflight_q} - {2'b00, pop};
    assign rinc       = !rEmpty && !rrst && (load_after < 3'(BUF_DEPTH));

    assign inflight_d = rinc;
    assign count_d    = count_q + {{(CSIZE-1){1'b0}}, pop};

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk      (rclk),
        .rst      (rrst),
        .push     (inflight_q),
        .push_data(rData),
        .pop      (pop),
        .occ      (occ),
        .head     (m_data)
    );

    assign rd_count = count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for the FIFO read-side drain engine
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DSIZE = 8;
    localparam int CSIZE = 16;

    logic             rclk    = 1'b0;
    logic             rrst    = 1'b1;
    logic             m_ready = 1'b0;
    logic             rEmpty;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] rData = '0;
    logic [DSIZE-1:0] m_data;
    logic [CSIZE-1:0] rd_count;

    logic [DSIZE-1:0] mem [0:1023];
    int unsigned      wr_ptr = 0;
    int unsigned      rd_ptr = 0;
    logic [DSIZE-1:0] exp_q [$];

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_total = 0;
    int cyc       = 0;
    int pop_cycles = 0;
    int first_pop  = -1;
    int last_pop   = -1;
    logic             stall_prev = 1'b0;
    logic [DSIZE-1:0] stall_data = '0;

    fifo_rd_stream #(.DSIZE(DSIZE), .CSIZE(CSIZE)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rEmpty  (rEmpty),
        .rData   (rData),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .rd_count(rd_count)
    );

    always #5 rclk = ~rclk;

    // FIFO read-port model: registered data one cycle after an accepted rinc.
    assign rEmpty = (wr_ptr == rd_ptr);
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rData  <= mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge rclk) begin
        logic [DSIZE-1:0] exp_w;
        if (rrst) begin
            stall_prev = 1'b0;
        end else begin
            n_tests++;
            if (({1'b0, dut.u_skid.occ_q} + {2'b00, dut.inflight_q}) > 3'd2) begin
                n_fail++;
                $display("FAIL occ_inflight_bound: occ=%0d inflight=%0d, required sum<=2",
                         dut.u_skid.occ_q, dut.inflight_q);
            end
            n_tests++;
            if (rinc && rEmpty) begin
                n_fail++;
                $display("FAIL rinc_when_empty: rinc=1 rEmpty=1, required rinc=0");
            end
            if (stall_prev) begin
                n_tests++;
                if (m_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: m_data=%h, required %h", m_data, stall_data);
                end
            end
            if (m_valid && m_ready) begin
                n_tests++;
                pop_cycles++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: m_data=%h delivered, required no word", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL sb_data: m_data=%h, required %h", m_data, exp_w);
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [DSIZE-1:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
        exp_q.push_back(d);
        exp_total++;
    endtask

    task automatic reset_window();
        pop_cycles = 0;
        first_pop  = -1;
        last_pop   = -1;
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        @(negedge rclk);
        while ((exp_q.size() != 0 || m_valid) && c < max_cycles) begin
            @(negedge rclk);
            c++;
        end
        n_tests++;
        if (c >= max_cycles) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles, required 0",
                     exp_q.size(), c);
        end
    endtask

    task automatic test_reset();
        rrst    = 1'b1;
        m_ready = 1'b1;
        mem[wr_ptr % 1024] = 8'h3C;
        wr_ptr++;
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            n_tests++;
            if (rinc !== 1'b0 || m_valid !== 1'b0 || rd_count !== '0) begin
                n_fail++;
                $display("FAIL reset_state: rinc=%b m_valid=%b rd_count=%h, required 0/0/0000",
                         rinc, m_valid, rd_count);
            end
        end
        tick();
        wr_ptr = rd_ptr;
        rrst   = 1'b0;
    endtask

    task automatic test_single();
        tick();
        m_ready = 1'b1;
        push_word(8'hA5);
        @(negedge rclk);
        n_tests++;
        if (rinc !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_issue: rinc=%b m_valid=%b, required 1/0", rinc, m_valid);
        end
        @(negedge rclk);
        n_tests++;
        if (rinc !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_inflight: rinc=%b m_valid=%b, required 0/0", rinc, m_valid);
        end
        @(negedge rclk);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_out: m_valid=%b m_data=%h, required 1/a5", m_valid, m_data);
        end
        @(negedge rclk);
        n_tests++;
        if (m_valid !== 1'b0 || rd_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_count: m_valid=%b rd_count=%0d, required 0/1", m_valid, rd_count);
        end
    endtask

    task automatic test_stream();
        int rinc_cnt, rinc_first, rinc_last;
        tick();
        m_ready = 1'b1;
        reset_window();
        for (int i = 0; i < 16; i++) push_word(8'(i));
        rinc_cnt = 0; rinc_first = -1; rinc_last = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (rinc) begin
                rinc_cnt++;
                if (rinc_first < 0) rinc_first = i;
                rinc_last = i;
            end
        end
        drain(20);
        n_tests++;
        if (rinc_cnt != 16 || rinc_last - rinc_first + 1 != 16) begin
            n_fail++;
            $display("FAIL stream_rinc: %0d rinc over span %0d, required 16 over 16",
                     rinc_cnt, rinc_last - rinc_first + 1);
        end
        n_tests++;
        if (pop_cycles != 16 || last_pop - first_pop + 1 != 16) begin
            n_fail++;
            $display("FAIL stream_pops: %0d pops over span %0d, required 16 over 16",
                     pop_cycles, last_pop - first_pop + 1);
        end
        n_tests++;
        if (rd_count !== 16'(exp_total)) begin
            n_fail++;
            $display("FAIL stream_count: rd_count=%0d, required %0d", rd_count, 16'(exp_total));
        end
    endtask

    task automatic test_backpressure();
        int rinc_cnt;
        tick();
        m_ready = 1'b0;
        reset_window();
        for (int i = 0; i < 5; i++) push_word(8'(i));
        rinc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            if (rinc) rinc_cnt++;
        end
        n_tests++;
        if (rinc_cnt != 2) begin
            n_fail++;
            $display("FAIL bp_rinc: %0d rinc cycles, required 2", rinc_cnt);
        end
        n_tests++;
        if (dut.u_skid.occ_q !== OCC_TWO || m_valid !== 1'b1 || m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_hold: occ=%0d m_valid=%b m_data=%h, required 2/1/00",
                     dut.u_skid.occ_q, m_valid, m_data);
        end
        tick();
        m_ready = 1'b1;
        drain(20);
        n_tests++;
        if (pop_cycles != 5 || last_pop - first_pop + 1 != 5) begin
            n_fail++;
            $display("FAIL bp_release: %0d pops over span %0d, required 5 over 5",
                     pop_cycles, last_pop - first_pop + 1);
        end
    endtask

    task automatic test_random();
        int sent, c;
        sent = 0;
        c    = 0;
        tick();
        while ((sent < 200 || exp_q.size() != 0 || m_valid) && c < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 200 && $urandom_range(0, 1) == 1) begin
                push_word(8'($urandom));
                sent++;
            end
            tick();
            c++;
        end
        m_ready = 1'b1;
        n_tests++;
        if (c >= 3000) begin
            n_fail++;
            $display("FAIL random_timeout: sent=%0d left=%0d, required 200/0", sent, exp_q.size());
        end
        @(negedge rclk);
        n_tests++;
        if (rd_count !== 16'(exp_total)) begin
            n_fail++;
            $display("FAIL random_count: rd_count=%0d, required %0d", rd_count, 16'(exp_total));
        end
    endtask

    task automatic test_wrap_reset();
        int c;
        c = 0;
        tick();
        m_ready = 1'b1;
        while (exp_total < 65535 && c < 70000) begin
            if (wr_ptr - rd_ptr < 512) push_word(8'(exp_total));
            tick();
            c++;
        end
        drain(50);
        n_tests++;
        if (rd_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: rd_count=%h, required ffff", rd_count);
        end
        tick();
        push_word(8'h5A);
        drain(20);
        n_tests++;
        if (rd_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_count: rd_count=%h, required 0000", rd_count);
        end
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) tick();
        @(negedge rclk);
        n_tests++;
        if (dut.u_skid.occ_q !== OCC_TWO) begin
            n_fail++;
            $display("FAIL reset_setup: occ=%0d, required 2", dut.u_skid.occ_q);
        end
        tick();
        rrst = 1'b1;
        wr_ptr = rd_ptr;
        exp_q.delete();
        exp_total = 0;
        tick();
        @(negedge rclk);
        n_tests++;
        if (m_valid !== 1'b0 || rd_count !== '0 || rinc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: m_valid=%b rd_count=%h rinc=%b, required 0/0000/0",
                     m_valid, rd_count, rinc);
        end
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
